// File: rtl/imem_loader_if.sv
// Boot byte stream in, instruction-memory write port out.
// master = loader side, slave = boot link / memory side.
interface imem_loader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic [7:0]            byte_i;
    logic                  byte_valid_i;
    logic                  byte_ready_o;
    logic                  wr_en_o;
    logic [ADDR_WIDTH-1:0] wr_address_o;
    logic [DATA_WIDTH-1:0] wr_data_o;

    modport master (
        input  byte_i, byte_valid_i,
        output byte_ready_o, wr_en_o, wr_address_o, wr_data_o
    );

    modport slave (
        output byte_i, byte_valid_i,
        input  byte_ready_o, wr_en_o, wr_address_o, wr_data_o
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: packs little-endian bytes into 32-bit words and writes imem, then releases CPU reset.
// Latency: write strobe the cycle after the 4th byte of a word; done one cycle after the last write.
// Backpressure: byte_ready_o only in RECV; stalls on byte_valid_i indefinitely.
module imem_loader #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int PROGRAM_LENGTH = 10
) (
    input  logic               clk,
    input  logic               rst_ni,
    input  logic               start_i,
    imem_loader_if.master      bus,
    output logic               busy_o,
    output logic               done_o,
    output logic               cpu_reset_no
);
    localparam int WI = (PROGRAM_LENGTH > 1) ? $clog2(PROGRAM_LENGTH) : 1;
    localparam logic [WI-1:0] LAST_WORD = WI'(PROGRAM_LENGTH - 1);

    typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [WI-1:0]         word_idx_q;
    logic [1:0]            byte_idx_q;
    logic [DATA_WIDTH-1:0] word_q;
    logic                  accept;
    logic                  last_word;
    logic                  restart;

    assign accept    = (state_q == RECV) && bus.byte_valid_i;
    assign last_word = (word_idx_q == LAST_WORD);
    assign restart   = ((state_q == IDLE) || (state_q == DONE)) && start_i;

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every output is a pure decode of registered state.
    always_comb begin
        state_d          = state_q;
        bus.byte_ready_o = 1'b0;
        bus.wr_en_o      = 1'b0;
        busy_o           = 1'b0;
        done_o           = 1'b0;
        cpu_reset_no     = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_i) state_d = RECV;
            end
            RECV: begin
                bus.byte_ready_o = 1'b1;
                busy_o           = 1'b1;
                if (accept && (byte_idx_q == 2'd3)) state_d = WRITE;
            end
            WRITE: begin
                bus.wr_en_o = 1'b1;
                busy_o      = 1'b1;
                state_d     = last_word ? DONE : RECV;
            end
            DONE: begin
                done_o       = 1'b1;
                cpu_reset_no = 1'b1;
                if (start_i) state_d = RECV;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            word_q     <= '0;
        end else if (restart) begin
            word_idx_q <= '0;
            byte_idx_q <= 2'd0;
            word_q     <= '0;
        end else begin
            if (accept) begin
                word_q[{byte_idx_q, 3'b000} +: 8] <= bus.byte_i;
                byte_idx_q                        <= byte_idx_q + 2'd1;
            end
            // Index saturates at the last word, so no write can land past the program.
            if ((state_q == WRITE) && !last_word) begin
                word_idx_q <= word_idx_q + WI'(1);
            end
        end
    end

    assign bus.wr_address_o = ADDR_WIDTH'({word_idx_q, 2'b00});
    assign bus.wr_data_o    = word_q;
endmodule

// File: tb/tb_imem_loader.sv
// Directed/random bench for imem_loader with a queue-based reference of expected imem writes.
module tb_imem_loader;
    localparam int PL = 3;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    logic start_i = 1'b0;
    logic busy_o, done_o, cpu_reset_no;
    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    int   ready_in_write = 0;
    logic [63:0] wr_q[$];

    imem_loader_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

    imem_loader #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .PROGRAM_LENGTH(PL)) dut (
        .clk          (clk),
        .rst_ni       (rst_ni),
        .start_i      (start_i),
        .bus          (bus.master),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .cpu_reset_no (cpu_reset_no)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_ni && bus.wr_en_o) begin
            wr_q.push_back({bus.wr_address_o, bus.wr_data_o});
            if (bus.byte_ready_o) ready_in_write++;
        end
    end

    task automatic check(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [79:0] outs();
        return {11'd0, bus.byte_ready_o, bus.wr_en_o, bus.wr_address_o, bus.wr_data_o,
                busy_o, done_o, cpu_reset_no};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives bytes until all are accepted; optional random valid gaps and stray start pulses.
    task automatic send_stream(input logic [7:0] bytes[$], input bit gaps, input bit poke_start);
        int idx = 0;
        int budget = 0;
        bit acc;
        while (idx < bytes.size() && budget < 500) begin
            bus.byte_valid_i = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            bus.byte_i       = bus.byte_valid_i ? bytes[idx] : 8'($urandom);
            start_i          = poke_start ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            acc = bus.byte_valid_i && bus.byte_ready_o;
            tick();
            if (acc) idx++;
            budget++;
        end
        bus.byte_valid_i = 1'b0;
        start_i          = 1'b0;
        if (idx < bytes.size()) check("stream_budget", 80'(idx), 80'(bytes.size()));
    endtask

    // Reference: word w is bytes 4w..4w+3, first byte least significant, written at w*4.
    task automatic check_writes(input string tag, input logic [7:0] bytes[$]);
        int nwords = bytes.size() / 4;
        check({tag, "_count"}, 80'(wr_q.size()), 80'(nwords));
        for (int w = 0; w < nwords && w < wr_q.size(); w++) begin
            logic [31:0] exp_data;
            exp_data = 32'(bytes[4*w]) + (32'(bytes[4*w+1]) * 256)
                     + (32'(bytes[4*w+2]) * 65536) + (32'(bytes[4*w+3]) * 16777216);
            check({tag, "_word"}, 80'(wr_q[w]), 80'({32'(w * 4), exp_data}));
        end
        wr_q.delete();
    endtask

    task automatic rand_bytes(output logic [7:0] q[$], input int n);
        q.delete();
        for (int i = 0; i < n; i++) q.push_back(8'($urandom));
    endtask

    task automatic pulse_start();
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
    endtask

    task automatic check_finish(input string tag);
        check({tag, "_last_write"}, 80'({bus.wr_en_o, done_o, cpu_reset_no}), 80'(3'b100));
        tick();
        check({tag, "_done"},
              80'({bus.byte_ready_o, bus.wr_en_o, busy_o, done_o, cpu_reset_no}), 80'(5'b00011));
    endtask

    initial begin
        logic [7:0] prog[$];
        logic [7:0] stream[$];
        int t0;
        bus.byte_i       = 8'h00;
        bus.byte_valid_i = 1'b0;
        prog = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00,
                 8'h33, 8'h01, 8'h11, 8'h00};

        // Reset held with random inputs.
        for (int i = 0; i < 4; i++) begin
            start_i          = 1'($urandom);
            bus.byte_valid_i = 1'($urandom);
            bus.byte_i       = 8'($urandom);
            tick();
            check("reset_outputs", outs(), 80'd0);
        end
        start_i = 1'b0;
        bus.byte_valid_i = 1'b0;
        rst_ni = 1'b1;

        // Valid pulses in IDLE are ignored.
        for (int i = 0; i < 6; i++) begin
            bus.byte_valid_i = 1'($urandom);
            bus.byte_i       = 8'($urandom);
            tick();
            check("idle_ignores", 80'({bus.byte_ready_o, busy_o, bus.wr_en_o}), 80'd0);
        end
        bus.byte_valid_i = 1'b0;
        check("idle_no_writes", 80'(wr_q.size()), 80'd0);

        // Back-to-back known program; 5 cycles per word from the start edge.
        start_i = 1'b1;
        tick();
        t0 = cyc;
        start_i = 1'b0;
        check("start_ready", 80'({bus.byte_ready_o, busy_o, cpu_reset_no}), 80'(3'b110));
        send_stream(prog, 1'b0, 1'b0);
        check_finish("full_load");
        check("load_cycles", 80'(cyc - t0), 80'(5 * PL));
        check_writes("full_load", prog);

        // Reload from DONE with gappy valid and stray start pulses during RECV.
        pulse_start();
        check("reload_state", 80'({bus.byte_ready_o, done_o, cpu_reset_no}), 80'(3'b100));
        rand_bytes(stream, 4 * PL);
        send_stream(stream, 1'b1, 1'b1);
        check_finish("reload");
        check_writes("reload", stream);

        // Reset mid-load: word 0 written, word 1 partial.
        pulse_start();
        rand_bytes(stream, 6);
        send_stream(stream, 1'b1, 1'b0);
        check("midload_writes", 80'(wr_q.size()), 80'd1);
        wr_q.delete();
        rst_ni = 1'b0;
        #1;
        check("midload_reset", outs(), 80'd0);
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_reset_idle", 80'({bus.byte_ready_o, busy_o, cpu_reset_no}), 80'd0);

        // Fresh full load after reset.
        pulse_start();
        rand_bytes(stream, 4 * PL);
        send_stream(stream, 1'b1, 1'b0);
        check_finish("after_reset");
        check_writes("after_reset", stream);

        check("ready_in_write", 80'(ready_in_write), 80'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction memory. Accepts a byte stream over a valid/ready handshake, assembles little-endian 32-bit instruction words and issues one synchronous write per word to the instruction memory's write port at byte addresses 0, 4, 8, and so on. Holds the CPU core in reset until exactly PROGRAM_LENGTH words are written, then releases it. Sits between the external boot link (UART receiver or debug port) and the instruction memory.

## Interface
- ADDR_WIDTH, 32, width of wr_address_o (byte address)
- DATA_WIDTH, 32, instruction word width; fixed at 32 (4 bytes per word)
- PROGRAM_LENGTH, 10, number of words per load; must be ≥ 1
- clk  input  1  single clock; all state on rising edge
- rst_ni  input  1  asynchronous, active-low reset
- start_i  input  1  begin a load; sampled only in IDLE or DONE
- byte_i  input  8  incoming byte
- byte_valid_i  input  1  byte_i valid
- byte_ready_o  output  1  loader can accept a byte this cycle
- wr_en_o  output  1  instruction-memory write strobe, one cycle per word
- wr_address_o  output  ADDR_WIDTH  byte address = word_index*4, zero-extended
- wr_data_o  output  DATA_WIDTH  assembled word
- busy_o  output  1  high in RECV or WRITE
- done_o  output  1  high in DONE
- cpu_reset_no  output  1  active-low CPU reset; 0 until load completes

## Operation
- States: IDLE, RECV, WRITE, DONE. All outputs are decoded from registers only, with no combinational path from any input to any output.
- IDLE:
  - byte_ready_o=0; byte_valid_i ignored.
  - start_i=1 → RECV, with word_index=0 and byte_index=0.
- RECV:
  - byte_ready_o=1. A byte is accepted when byte_valid_i && byte_ready_o at a clock edge.
  - The k-th accepted byte (k=0..3) is stored in wr_data_o[8k+7:8k], so the first byte is the LSB.
  - byte_index increments per accepted byte. On the 4th byte → WRITE, and byte_index returns to 0.
  - start_i is ignored.
- WRITE:
  - Exactly one cycle: wr_en_o=1, byte_ready_o=0, wr_address_o=word_index<<2, wr_data_o stable.
  - If word_index==PROGRAM_LENGTH-1 → DONE. Otherwise word_index+1 and → RECV.
- DONE:
  - done_o=1, cpu_reset_no=1, byte_ready_o=0.
  - start_i=1 → RECV with counters cleared, cpu_reset_no=0 and done_o=0, i.e. a reload.
- word_index width is max(1, $clog2(PROGRAM_LENGTH)). It never exceeds PROGRAM_LENGTH-1, so there is no wrap-around and no write beyond the program.
- Stalls: byte_valid_i low mid-word holds the partial word and byte_index indefinitely. There is no timeout.
- Reset asserted at any point:
  - Immediately returns to IDLE and discards any partial word.
  - cpu_reset_no=0. Memory contents already written are untouched.

## Timing
- Reset values: byte_ready_o=0, wr_en_o=0, wr_address_o=0, wr_data_o=0, busy_o=0, done_o=0, cpu_reset_no=0; state IDLE.
- start_i high at edge T (in IDLE) → byte_ready_o=1 from T+1.
- 4th byte of a word accepted at edge N → wr_en_o=1 during cycle N to N+1; the memory captures at edge N+1; byte_ready_o=1 again from N+1.
- Peak rate: 4 bytes plus 1 write cycle = 5 cycles per word. Minimum load is 5*PROGRAM_LENGTH cycles after RECV entry.
- Final WRITE cycle ending at edge M → done_o=1 and cpu_reset_no=1 from M onward. The CPU leaves reset one cycle after the last word is in memory.
- wr_address_o and wr_data_o may change outside WRITE; consumers qualify them with wr_en_o.

## Test plan
- Reset: hold rst_ni=0 with random inputs → all outputs 0, byte_ready_o=0; release reset → still IDLE until start_i.
- Full load, PROGRAM_LENGTH=3:
  - Bytes 13 00 00 00, 93 00 10 00, 33 01 11 00 streamed back-to-back → writes (0x0, 0x00000013), (0x4, 0x00100093), (0x8, 0x00110133), each with wr_en_o high one cycle.
  - done_o=1 and cpu_reset_no=1 the cycle after the third write.
- Backpressure: same stream with byte_valid_i toggling randomly → identical write sequence; no byte lost or duplicated; byte_ready_o=0 during each WRITE cycle.
- Ignored inputs:
  - byte_valid_i pulses in IDLE → no state change and no writes.
  - start_i pulses during RECV → word_index and byte_index unaffected.
- Reset mid-load: assert rst_ni after 6 bytes (word 0 written, word 1 partial) → IDLE and cpu_reset_no=0; a new full load writes word 1 correctly from fresh bytes.
- Reload from DONE: start_i=1 in DONE → cpu_reset_no=0, done_o=0; the next stream rewrites from address 0x0.
